// File: rtl/ovw_fifo_pkg.sv
// ovw_fifo_pkg
//   Shared types for the overwrite-capable FIFO.
//   ovw_mode_t selects what happens to a write that arrives while the FIFO is
//   full and no read is popping an entry in the same cycle:
//     DROP_OLDEST : the new word replaces the oldest stored entry
//     DROP_NEWEST : the new word is discarded
package ovw_fifo_pkg;

  typedef enum logic {
    DROP_OLDEST = 1'b0,
    DROP_NEWEST = 1'b1
  } ovw_mode_t;

endpackage : ovw_fifo_pkg

// File: rtl/ovw_fifo_mem.sv
// ovw_fifo_mem
//   FIFO storage array with one synchronous write port and one asynchronous
//   read port. The asynchronous read gives the parent FIFO its
//   first-word fall-through behaviour. Contents are never reset.
//
// Ports
//   clk    in   clock; writes take effect on the rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module ovw_fifo_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule : ovw_fifo_mem

// File: rtl/ovw_fifo.sv
// ovw_fifo
//   First-word fall-through FIFO with a configurable overflow policy.
//   A write into a full FIFO (with no simultaneous read) either overwrites the
//   oldest entry or is discarded, depending on MODE; either way it is counted
//   as a drop. Reads of an empty FIFO are ignored and flagged as underflow.
//
// Parameters
//   DEPTH    number of entries, power of two, >= 2
//   DWIDTH   data width
//   MODE     overflow policy (DROP_OLDEST / DROP_NEWEST)
//   AF_LEVEL almost-full threshold, 1..DEPTH
//   CWIDTH   drop counter width
//
// Ports
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   clear           in   synchronous flush (pointers to 0, drop_cnt kept)
//   write_en        in   write request
//   wdata           in   write data
//   read_en         in   pop request
//   rdata           out  head entry (don't-care while empty)
//   empty_flg       out  count == 0
//   full_flg        out  count == DEPTH
//   afull_flg       out  count >= AF_LEVEL
//   count           out  occupancy
//   drop_pulse      out  one-cycle pulse after a dropped word
//   underflow_pulse out  one-cycle pulse after a read on empty
//   drop_cnt        out  saturating count of dropped words
module ovw_fifo
  import ovw_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DWIDTH   = 8,
  parameter ovw_mode_t   MODE     = DROP_OLDEST,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned CWIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     write_en,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic                     read_en,
  output logic [DWIDTH-1:0]        rdata,
  output logic                     empty_flg,
  output logic                     full_flg,
  output logic                     afull_flg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_pulse,
  output logic                     underflow_pulse,
  output logic [CWIDTH-1:0]        drop_cnt
);

  localparam int unsigned AWIDTH = $clog2(DEPTH);
  // One extra pointer bit distinguishes full from empty when the address
  // bits are equal.
  localparam int unsigned PWIDTH = AWIDTH + 1;
  localparam logic [PWIDTH-1:0] AF_THRESH = PWIDTH'(AF_LEVEL);
  localparam logic [PWIDTH-1:0] PTR_ONE   = PWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_ONE   = CWIDTH'(1);

  logic [PWIDTH-1:0] wptr_reg, wptr_next;
  logic [PWIDTH-1:0] rptr_reg, rptr_next;
  logic [CWIDTH-1:0] drop_cnt_reg, drop_cnt_next;
  logic              drop_pulse_reg;
  logic              underflow_pulse_reg;

  logic              mem_we;
  logic              drop_ev;
  logic              underflow_ev;
  logic              is_empty;
  logic              is_full;

  // Flags come straight from the pointer registers so they track every edge
  // without extra latency.
  assign is_empty = (wptr_reg == rptr_reg);
  assign is_full  = (wptr_reg[AWIDTH] != rptr_reg[AWIDTH]) &&
                    (wptr_reg[AWIDTH-1:0] == rptr_reg[AWIDTH-1:0]);

  assign count     = wptr_reg - rptr_reg;
  assign empty_flg = is_empty;
  assign full_flg  = is_full;
  assign afull_flg = (count >= AF_THRESH);

  ovw_fifo_mem #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_reg[AWIDTH-1:0]),
    .wdata (wdata),
    .raddr (rptr_reg[AWIDTH-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    mem_we       = 1'b0;
    drop_ev      = 1'b0;
    underflow_ev = 1'b0;

    if (clear) begin
      // Flush wins over any request in the same cycle and raises no events.
      wptr_next = '0;
      rptr_next = '0;
    end else if (write_en && read_en) begin
      // Simultaneous read and write never drops: when full, the pop frees
      // the slot the write lands in.
      mem_we    = 1'b1;
      wptr_next = wptr_reg + PTR_ONE;
      if (is_empty) begin
        underflow_ev = 1'b1;
      end else begin
        rptr_next = rptr_reg + PTR_ONE;
      end
    end else if (write_en) begin
      if (!is_full) begin
        mem_we    = 1'b1;
        wptr_next = wptr_reg + PTR_ONE;
      end else if (MODE == DROP_OLDEST) begin
        // wptr aliases rptr's slot when full, so this overwrites the head;
        // advancing both keeps the occupancy at DEPTH.
        mem_we    = 1'b1;
        wptr_next = wptr_reg + PTR_ONE;
        rptr_next = rptr_reg + PTR_ONE;
        drop_ev   = 1'b1;
      end else begin
        drop_ev = 1'b1;
      end
    end else if (read_en) begin
      if (!is_empty) begin
        rptr_next = rptr_reg + PTR_ONE;
      end else begin
        underflow_ev = 1'b1;
      end
    end
  end

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (drop_ev && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg            <= '0;
      rptr_reg            <= '0;
      drop_cnt_reg        <= '0;
      drop_pulse_reg      <= 1'b0;
      underflow_pulse_reg <= 1'b0;
    end else begin
      wptr_reg            <= wptr_next;
      rptr_reg            <= rptr_next;
      drop_cnt_reg        <= drop_cnt_next;
      drop_pulse_reg      <= drop_ev;
      underflow_pulse_reg <= underflow_ev;
    end
  end

  assign drop_pulse      = drop_pulse_reg;
  assign underflow_pulse = underflow_pulse_reg;
  assign drop_cnt        = drop_cnt_reg;

endmodule : ovw_fifo

// File: tb/tb_ovw_fifo.sv
// tb_ovw_fifo
//   Directed bench for ovw_fifo. Two instances (DROP_OLDEST and DROP_NEWEST)
//   receive identical stimulus; expected values are hand-computed constants.
module tb_ovw_fifo;
  import ovw_fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       write_en;
  logic [7:0] wdata;
  logic       read_en;

  logic [7:0] rdata_o, rdata_n;
  logic       empty_o, empty_n;
  logic       full_o, full_n;
  logic       afull_o, afull_n;
  logic [2:0] count_o, count_n;
  logic       drop_p_o, drop_p_n;
  logic       udf_p_o, udf_p_n;
  logic [7:0] drop_cnt_o, drop_cnt_n;

  int checks;
  int failures;

  ovw_fifo #(.DEPTH(4), .DWIDTH(8), .MODE(DROP_OLDEST), .AF_LEVEL(3), .CWIDTH(8)) dut_old (
    .clk(clk), .rst_n(rst_n), .clear(clear), .write_en(write_en), .wdata(wdata),
    .read_en(read_en), .rdata(rdata_o), .empty_flg(empty_o), .full_flg(full_o),
    .afull_flg(afull_o), .count(count_o), .drop_pulse(drop_p_o),
    .underflow_pulse(udf_p_o), .drop_cnt(drop_cnt_o)
  );

  ovw_fifo #(.DEPTH(4), .DWIDTH(8), .MODE(DROP_NEWEST), .AF_LEVEL(3), .CWIDTH(8)) dut_new (
    .clk(clk), .rst_n(rst_n), .clear(clear), .write_en(write_en), .wdata(wdata),
    .read_en(read_en), .rdata(rdata_n), .empty_flg(empty_n), .full_flg(full_n),
    .afull_flg(afull_n), .count(count_n), .drop_pulse(drop_p_n),
    .underflow_pulse(udf_p_n), .drop_cnt(drop_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [31:0] obs_old,
                            input logic [31:0] obs_new, input logic [31:0] exp);
    check_eq({"old.", tag}, obs_old, exp);
    check_eq({"new.", tag}, obs_new, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check_both({tag, ".count"}, 32'(count_o), 32'(count_n), 0);
    check_both({tag, ".empty"}, 32'(empty_o), 32'(empty_n), 1);
    check_both({tag, ".full"}, 32'(full_o), 32'(full_n), 0);
    check_both({tag, ".afull"}, 32'(afull_o), 32'(afull_n), 0);
    check_both({tag, ".drop_cnt"}, 32'(drop_cnt_o), 32'(drop_cnt_n), 0);
    check_both({tag, ".drop_pulse"}, 32'(drop_p_o), 32'(drop_p_n), 0);
    check_both({tag, ".underflow"}, 32'(udf_p_o), 32'(udf_p_n), 0);
  endtask

  // One clock transaction; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    write_en = wr;
    wdata    = wd;
    read_en  = rd;
    clear    = clr;
    @(posedge clk);
    #1;
    $display("txn t=%0t wr=%0b wdata=0x%02h rd=%0b clr=%0b | old count=%0d rdata=0x%02h drop_cnt=%0d | new count=%0d rdata=0x%02h drop_cnt=%0d",
             $time, wr, wd, rd, clr, count_o, rdata_o, drop_cnt_o, count_n, rdata_n, drop_cnt_n);
    write_en = 1'b0;
    read_en  = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tally_o;
    int tally_n;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    wdata    = 8'h00;

    // Reset state
    #12;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Overflow: write 0x01..0x06 into a 4-deep FIFO
    tally_o = 0;
    tally_n = 0;
    for (int v = 1; v <= 6; v++) begin
      step(1'b1, 8'(v), 1'b0, 1'b0);
      tally_o += int'(drop_p_o);
      tally_n += int'(drop_p_n);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tally_o += int'(drop_p_o);
    tally_n += int'(drop_p_n);
    check_eq("old.drop_pulse_cycles", 32'(tally_o), 2);
    check_eq("new.drop_pulse_cycles", 32'(tally_n), 2);
    check_both("ovf.count", 32'(count_o), 32'(count_n), 4);
    check_both("ovf.full", 32'(full_o), 32'(full_n), 1);
    check_both("ovf.afull", 32'(afull_o), 32'(afull_n), 1);
    check_both("ovf.drop_cnt", 32'(drop_cnt_o), 32'(drop_cnt_n), 2);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("old.ovf.rd%0d", i), 32'(rdata_o), 32'(3 + i));
      check_eq($sformatf("new.ovf.rd%0d", i), 32'(rdata_n), 32'(1 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_both("ovf.drained", 32'(empty_o), 32'(empty_n), 1);
    check_both("ovf.no_underflow", 32'(udf_p_o), 32'(udf_p_n), 0);

    // Fill to full, then read+write together while full
    for (int v = 0; v < 4; v++) begin
      step(1'b1, 8'(8'h10 + v), 1'b0, 1'b0);
      if (v == 1) check_both("fill.afull_at2", 32'(afull_o), 32'(afull_n), 0);
      if (v == 2) check_both("fill.afull_at3", 32'(afull_o), 32'(afull_n), 1);
    end
    check_both("fill.full", 32'(full_o), 32'(full_n), 1);
    step(1'b1, 8'h14, 1'b1, 1'b0);
    check_both("rw_full.count", 32'(count_o), 32'(count_n), 4);
    check_both("rw_full.drop_pulse", 32'(drop_p_o), 32'(drop_p_n), 0);
    check_both("rw_full.drop_cnt", 32'(drop_cnt_o), 32'(drop_cnt_n), 2);
    for (int i = 0; i < 4; i++) begin
      check_both($sformatf("rw_full.rd%0d", i), 32'(rdata_o), 32'(rdata_n), 32'(8'h11 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_both("rw_full.drained", 32'(count_o), 32'(count_n), 0);

    // Read on empty
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_both("udf.pulse", 32'(udf_p_o), 32'(udf_p_n), 1);
    check_both("udf.count", 32'(count_o), 32'(count_n), 0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check_both("udf.pulse_clears", 32'(udf_p_o), 32'(udf_p_n), 0);
    check_both("udf.rdata", 32'(rdata_o), 32'(rdata_n), 32'h0AA);
    check_both("udf.count1", 32'(count_o), 32'(count_n), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_both("udf.drain", 32'(empty_o), 32'(empty_n), 1);

    // Read+write on empty
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check_both("rw_empty.count", 32'(count_o), 32'(count_n), 1);
    check_both("rw_empty.rdata", 32'(rdata_o), 32'(rdata_n), 32'h055);
    check_both("rw_empty.underflow", 32'(udf_p_o), 32'(udf_p_n), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_both("rw_empty.drain", 32'(empty_o), 32'(empty_n), 1);

    // Clear with a concurrent write
    for (int v = 0; v < 3; v++) step(1'b1, 8'(8'h30 + v), 1'b0, 1'b0);
    check_both("clr.pre_count", 32'(count_o), 32'(count_n), 3);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check_both("clr.count", 32'(count_o), 32'(count_n), 0);
    check_both("clr.empty", 32'(empty_o), 32'(empty_n), 1);
    check_both("clr.drop_cnt", 32'(drop_cnt_o), 32'(drop_cnt_n), 2);
    check_both("clr.drop_pulse", 32'(drop_p_o), 32'(drop_p_n), 0);

    // Refill past full, then reset asynchronously mid-cycle
    for (int v = 0; v < 5; v++) step(1'b1, 8'(8'h40 + v), 1'b0, 1'b0);
    check_both("pre_rst.drop_pulse", 32'(drop_p_o), 32'(drop_p_n), 1);
    check_both("pre_rst.drop_cnt", 32'(drop_cnt_o), 32'(drop_cnt_n), 3);
    check_eq("old.pre_rst.rdata", 32'(rdata_o), 32'h041);
    check_eq("new.pre_rst.rdata", 32'(rdata_n), 32'h040);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check_both("post_rst.count", 32'(count_o), 32'(count_n), 1);
    check_both("post_rst.rdata", 32'(rdata_o), 32'(rdata_n), 32'h099);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ovw_fifo

// File: doc/ovw_fifo.md
OVW_FIFO -- requirements
Module: ovw_fifo

Interface
REQ-001 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DWIDTH, default 8: data word width.
REQ-003 Parameter MODE, default DROP_OLDEST: overflow policy, of type ovw_mode_t.
REQ-004 Parameter AF_LEVEL, default DEPTH-1: almost-full threshold, range 1..DEPTH.
REQ-005 Parameter CWIDTH, default 8: drop counter width.
REQ-006 Port clk  in  1  clock; all state changes on the rising edge.
REQ-007 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-008 Port clear  in  1  synchronous flush.
REQ-009 Port write_en  in  1  write request.
REQ-010 Port wdata  in  DWIDTH  write data.
REQ-011 Port read_en  in  1  read (pop) request.
REQ-012 Port rdata  out  DWIDTH  head entry, first-word fall-through.
REQ-013 Port empty_flg  out  1  count==0.
REQ-014 Port full_flg  out  1  count==DEPTH.
REQ-015 Port afull_flg  out  1  count>=AF_LEVEL.
REQ-016 Port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 Port drop_pulse  out  1  registered; high one cycle after a dropped word.
REQ-018 Port underflow_pulse  out  1  registered; high one cycle after a read on empty.
REQ-019 Port drop_cnt  out  CWIDTH  saturating total of dropped words.

Function
REQ-020 Pointers SHALL be $clog2(DEPTH)+1 bits; empty = pointers equal, full = MSBs differ and lower bits equal; count = wptr-rptr, modulo width.
REQ-021 rdata SHALL equal mem[rptr] combinationally; its value while empty_flg=1 is don't-care.
REQ-022 Write, not full: store wdata at wptr; wptr+1.
REQ-023 Write, full, no read, MODE=DROP_OLDEST: overwrite oldest entry; wptr+1 and rptr+1; count unchanged; drop event.
REQ-024 Write, full, no read, MODE=DROP_NEWEST: discard wdata; pointers and memory unchanged; drop event.
REQ-025 Read, not empty: rptr+1.
REQ-026 Read, empty: pointers unchanged (no wrap-around corruption); underflow event.
REQ-027 Read and write, not empty, including full: both performed; count unchanged; no drop event.
REQ-028 Read and write, empty: write accepted; read ignored; count becomes 1; underflow event.
REQ-029 clear=1: wptr=rptr=0 and count 0; read_en and write_en ignored that cycle; no events; drop_cnt retained.
REQ-030 Drop event: drop_pulse=1 next cycle; drop_cnt+1, saturating at all-ones.
REQ-031 Underflow event: underflow_pulse=1 next cycle.
REQ-032 Flags and count SHALL reflect the pointers after each edge with no added latency (combinational from pointer registers).

Reset
REQ-033 rst_n low SHALL asynchronously zero wptr, rptr, drop_cnt, drop_pulse and underflow_pulse; empty_flg=1, full_flg=0, count=0; afull_flg=0.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard all stored entries; the first write after release lands at address 0.

Structure
REQ-036 Package ovw_fifo_pkg SHALL hold enum ovw_mode_t {DROP_OLDEST, DROP_NEWEST}.
REQ-037 Storage SHALL be sub-module ovw_fifo_mem: one synchronous write port and one asynchronous read port, parametrised by DEPTH and DWIDTH.
REQ-038 Pointer, flag and counter logic SHALL reside in ovw_fifo.

Verification (DEPTH=4, DWIDTH=8)
REQ-039 DROP_OLDEST: write 0x01..0x06, then read 4 -> reads 0x03,0x04,0x05,0x06; drop_cnt=2; two drop_pulse cycles.
REQ-040 DROP_NEWEST: write 0x01..0x06, then read 4 -> reads 0x01..0x04; drop_cnt=2; count 4 before the reads.
REQ-041 Fill to full (0x10..0x13), then read+write 0x14 in one cycle -> count stays 4; drop_pulse=0; subsequent reads 0x11..0x14.
REQ-042 Empty, read_en=1 -> underflow_pulse=1 next cycle, count=0; next write 0xAA -> rdata=0xAA, count=1.
REQ-043 Empty, read+write 0x55 -> count=1, rdata=0x55, underflow_pulse=1.
REQ-044 Fill 3 entries, assert clear with write 0x77 -> count=0, empty_flg=1, drop_cnt unchanged; then assert rst_n low mid-stream -> all outputs return to reset values asynchronously.
